// File: rtl/sc_acc_pkg.sv
// Shared types and default sizing for the sc_acc lane-parallel frame accumulator.
package sc_acc_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_LANES      = 16;
  localparam int DEF_ACC_WIDTH  = 40;
  localparam int DEF_LEN_WIDTH  = 8;

  // IDLE: waiting for the first beat of a frame
  // ACC : accumulating the remaining beats
  // HOLD: result presented, waiting for downstream acceptance
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/sc_acc_lane.sv
// One accumulation lane: load/add of a zero-extended beat with sticky overflow.
// Build option SC_ACC_SAT_EN: clamp an overflowing lane at all-ones instead of wrapping.
module sc_acc_lane #(
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 40
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  load_i,
  input  logic                  add_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [ACC_WIDTH-1:0]  acc_o,
  output logic                  ovf_o
);

  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 ovf_q, ovf_d;
  logic [ACC_WIDTH-1:0] ext;
  logic [ACC_WIDTH:0]   sum;

  assign ext = ACC_WIDTH'(data_i);
  assign sum = {1'b0, acc_q} + {1'b0, ext};

  // Next accumulator value; the carry out of the extra sum bit flags overflow.
  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (clear_i) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (load_i) begin
      acc_d = ext;
      ovf_d = 1'b0;
    end else if (add_i) begin
      ovf_d = ovf_q | sum[ACC_WIDTH];
`ifdef SC_ACC_SAT_EN
      // Once clamped, any further add carries out again, so the lane stays at max.
      acc_d = sum[ACC_WIDTH] ? '1 : sum[ACC_WIDTH-1:0];
`else
      acc_d = sum[ACC_WIDTH-1:0];
`endif
    end
  end

  // Lane registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign acc_o = acc_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/sc_acc.sv
// sc_acc: frame accumulator summing len_i beats per lane and presenting the sums
// with a valid/ready handshake. Optional macro SC_ACC_SAT_EN selects saturating lanes.
module sc_acc
  import sc_acc_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LANES      = DEF_LANES,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          clear_i,
  input  logic [LEN_WIDTH-1:0]          len_i,
  input  logic                          data_valid_i,
  output logic                          data_ready_o,
  input  logic [LANES*DATA_WIDTH-1:0]   data_i,
  output logic                          data_valid_o,
  input  logic                          data_ready_i,
  output logic [LANES*ACC_WIDTH-1:0]    data_o,
  output logic                          ovf_o
);

  if (ACC_WIDTH < DATA_WIDTH) begin : g_bad_width
    $error("sc_acc: ACC_WIDTH must be >= DATA_WIDTH");
  end

  state_e               state_q, state_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic                 rdy_en_q;
  logic                 beat;
  logic                 first_beat;
  logic                 acc_beat;
  logic [LANES-1:0]     lane_ovf;

  // rdy_en_q keeps ready low during reset and the cycle it is released.
  assign data_ready_o = rdy_en_q && (state_q != HOLD);
  assign data_valid_o = (state_q == HOLD);
  assign beat         = data_valid_i && data_ready_o && !clear_i;
  assign ovf_o        = |lane_ovf;

  // Next-state, beat counting and length capture.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    first_beat = 1'b0;
    acc_beat   = 1'b0;
    if (clear_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (beat) begin
            first_beat = 1'b1;
            len_d      = (len_i == '0) ? LEN_WIDTH'(1) : len_i;
            cnt_d      = LEN_WIDTH'(1);
            state_d    = (len_d == LEN_WIDTH'(1)) ? HOLD : ACC;
          end
        end
        ACC: begin
          if (beat) begin
            acc_beat = 1'b1;
            cnt_d    = cnt_q + LEN_WIDTH'(1);
            if (cnt_d == len_q) state_d = HOLD;
          end
        end
        HOLD: begin
          if (data_ready_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Control registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      len_q    <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      rdy_en_q <= 1'b1;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    sc_acc_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .ACC_WIDTH (ACC_WIDTH)
    ) u_lane (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .clear_i(clear_i),
      .load_i (first_beat),
      .add_i  (acc_beat),
      .data_i (data_i[k*DATA_WIDTH +: DATA_WIDTH]),
      .acc_o  (data_o[k*ACC_WIDTH +: ACC_WIDTH]),
      .ovf_o  (lane_ovf[k])
    );
  end

endmodule
